// File: rtl/serializer_param_if.sv
// Handshake and serial-output bundle between a word producer/controller and serializer_param.
// The DUT side uses the slave modport; the producer/controller side uses master.
interface serializer_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  msb_first;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_en;
  logic                  ready;
  logic                  frame_valid;
  logic                  ser_data;
  logic                  ser_done;

  modport master (
    output P_DATA, Data_Valid, msb_first, par_en, par_typ, ser_en,
    input  ready, frame_valid, ser_data, ser_done
  );

  modport slave (
    input  P_DATA, Data_Valid, msb_first, par_en, par_typ, ser_en,
    output ready, frame_valid, ser_data, ser_done
  );
endinterface

// File: rtl/serializer_param.sv
// Parallel-to-serial converter with a one-entry holding buffer, per-word bit order
// and optional parity, paced by an external controller through ser_en/ser_done.
module serializer_param #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  serializer_param_if.slave   bus
);
  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] DW_C  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  // cfg packing: [2] msb_first, [1] par_en, [0] par_typ
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [2:0]            buf_cfg_q,  buf_cfg_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [2:0]            act_cfg_q,  act_cfg_d;
  logic                  act_valid_q, act_valid_d;
  logic [CW-1:0]         count_q,    count_d;

  logic [CW-1:0]         frame_len;
  logic                  accept;
  logic                  xfer;
  logic                  shift;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  ser_bit;

  assign frame_len = DW_C + {{(CW-1){1'b0}}, act_cfg_q[1]};
  assign accept    = bus.Data_Valid && !buf_full_q;
  assign xfer      = buf_full_q && !act_valid_q && !bus.ser_en;
  assign shift     = bus.ser_en && act_valid_q && (count_q < frame_len);

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_cfg_d   = buf_cfg_q;
    buf_full_d  = buf_full_q;
    act_data_d  = act_data_q;
    act_cfg_d   = act_cfg_q;
    act_valid_d = act_valid_q;
    count_d     = count_q;

    if (accept) begin
      buf_data_d = bus.P_DATA;
      buf_cfg_d  = {bus.msb_first, bus.par_en, bus.par_typ};
      buf_full_d = 1'b1;
    end

    if (xfer) begin
      act_data_d  = buf_data_q;
      act_cfg_d   = buf_cfg_q;
      act_valid_d = 1'b1;
      buf_full_d  = 1'b0;
    end

    // Dropping ser_en always rewinds the frame; act_valid survives an abort.
    if (!bus.ser_en) begin
      count_d = '0;
    end else if (shift) begin
      count_d = count_q + ONE_C;
      if (count_q == frame_len - ONE_C) begin
        act_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_data_q  <= '0;
      buf_cfg_q   <= '0;
      buf_full_q  <= 1'b0;
      act_data_q  <= '0;
      act_cfg_q   <= '0;
      act_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_cfg_q   <= buf_cfg_d;
      buf_full_q  <= buf_full_d;
      act_data_q  <= act_data_d;
      act_cfg_q   <= act_cfg_d;
      act_valid_q <= act_valid_d;
      count_q     <= count_d;
    end
  end

  // Shift instead of indexing so the selected bit always lands at a fixed position.
  always_comb begin
    shifted = act_cfg_q[2] ? (act_data_q << count_q) : (act_data_q >> count_q);
    ser_bit = 1'b0;
    if (bus.ser_en && act_valid_q) begin
      if (count_q < DW_C) begin
        ser_bit = act_cfg_q[2] ? shifted[DATA_WIDTH-1] : shifted[0];
      end else if ((count_q == DW_C) && act_cfg_q[1]) begin
        ser_bit = (^act_data_q) ^ act_cfg_q[0];
      end
    end
  end

  assign bus.ser_data    = ser_bit;
  assign bus.ser_done    = (count_q == frame_len);
  assign bus.ready       = !buf_full_q;
  assign bus.frame_valid = act_valid_q;
endmodule

// File: tb/tb_serializer_param.sv
// Self-checking bench for serializer_param at DATA_WIDTH 8 and 5, against a
// reference that derives each frame's bit list directly from the word and config.
module tb_serializer_param;
  logic       CLK;
  logic       RST;
  logic       sel;
  logic [7:0] pdata;
  logic       dv, msb, pe, pt, en;

  int checks = 0;
  int errors = 0;

  serializer_param_if #(.DATA_WIDTH(8)) if8 ();
  serializer_param_if #(.DATA_WIDTH(5)) if5 ();

  serializer_param #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(if8));
  serializer_param #(.DATA_WIDTH(5)) dut5 (.CLK(CLK), .RST(RST), .bus(if5));

  assign if8.P_DATA     = pdata;
  assign if8.Data_Valid = dv & ~sel;
  assign if8.msb_first  = msb;
  assign if8.par_en     = pe;
  assign if8.par_typ    = pt;
  assign if8.ser_en     = en & ~sel;
  assign if5.P_DATA     = pdata[4:0];
  assign if5.Data_Valid = dv & sel;
  assign if5.msb_first  = msb;
  assign if5.par_en     = pe;
  assign if5.par_typ    = pt;
  assign if5.ser_en     = en & sel;

  wire o_ready = sel ? if5.ready       : if8.ready;
  wire o_fv    = sel ? if5.frame_valid : if8.frame_valid;
  wire o_sd    = sel ? if5.ser_data    : if8.ser_data;
  wire o_done  = sel ? if5.ser_done    : if8.ser_done;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int width_now();
    return sel ? 5 : 8;
  endfunction

  // Bit k of a frame: data bits in the chosen order, then parity over the word.
  function automatic logic model_bit(input logic [7:0] word, input logic m,
                                     input logic p_en, input logic p_typ, input int k);
    int w = width_now();
    if (k < w) return m ? word[w-1-k] : word[k];
    if (k == w && p_en) return logic'(($countones(word) % 2) != 0) ^ p_typ;
    return 1'b0;
  endfunction

  task automatic load(input logic [7:0] word, input logic m, input logic p_en, input logic p_typ);
    @(negedge CLK);
    pdata = word; msb = m; pe = p_en; pt = p_typ; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    #1 chk("ready_after_accept", o_ready, 1'b0);
  endtask

  task automatic wait_xfer();
    @(negedge CLK);
    #1;
    chk("fv_after_xfer", o_fv, 1'b1);
    chk("ready_after_xfer", o_ready, 1'b1);
  endtask

  task automatic expect_bits(input logic [7:0] word, input logic m, input logic p_en,
                             input logic p_typ, input int k0, input int n);
    int len = width_now() + int'(p_en);
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge CLK);
      en = 1'b1;
      #1;
      chk("ser_data", o_sd, model_bit(word, m, p_en, p_typ, k));
      chk("done_low_mid", o_done, 1'b0);
      chk("fv_mid", o_fv, 1'b1);
    end
    if (k0 + n == len) begin
      @(negedge CLK);
      en = 1'b1;
      #1;
      chk("done_high", o_done, 1'b1);
      chk("fv_after_frame", o_fv, 1'b0);
      chk("ser_data_after_frame", o_sd, 1'b0);
    end
  endtask

  task automatic stop_en(input logic done_exp);
    @(negedge CLK);
    en = 1'b0;
    #1 chk("done_while_en_low", o_done, done_exp);
  endtask

  task automatic full_frame(input logic [7:0] word, input logic m, input logic p_en, input logic p_typ);
    int len = width_now() + int'(p_en);
    load(word, m, p_en, p_typ);
    wait_xfer();
    expect_bits(word, m, p_en, p_typ, 0, len);
    stop_en(1'b1);
    @(negedge CLK);
    #1 chk("done_cleared", o_done, 1'b0);
  endtask

  initial begin
    RST = 1'b0; sel = 1'b0; pdata = '0; dv = 1'b0; msb = 1'b0; pe = 1'b0; pt = 1'b0; en = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_fv", o_fv, 1'b0);
    chk("rst_sd", o_sd, 1'b0);
    chk("rst_done", o_done, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    // ser_en with nothing loaded stays silent
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      en = 1'b1;
      #1;
      chk("idle_en_sd", o_sd, 1'b0);
      chk("idle_en_done", o_done, 1'b0);
      chk("idle_en_fv", o_fv, 1'b0);
    end
    @(negedge CLK);
    en = 1'b0;

    full_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    full_frame(8'hA5, 1'b1, 1'b1, 1'b1);

    // Buffering: next word accepted mid-shift, extra word ignored while full
    load(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_xfer();
    expect_bits(8'h3C, 1'b0, 1'b0, 1'b0, 0, 2);
    pdata = 8'hF0; dv = 1'b1;
    expect_bits(8'h3C, 1'b0, 1'b0, 1'b0, 2, 1);
    dv = 1'b0;
    chk("ready_buf_full", o_ready, 1'b0);
    pdata = 8'h0F; dv = 1'b1;
    expect_bits(8'h3C, 1'b0, 1'b0, 1'b0, 3, 1);
    dv = 1'b0;
    chk("ready_still_full", o_ready, 1'b0);
    expect_bits(8'h3C, 1'b0, 1'b0, 1'b0, 4, 4);
    stop_en(1'b1);
    @(negedge CLK);
    #1;
    chk("buf_xfer_fv", o_fv, 1'b1);
    chk("buf_xfer_ready", o_ready, 1'b1);
    expect_bits(8'hF0, 1'b0, 1'b0, 1'b0, 0, 8);
    stop_en(1'b1);
    @(negedge CLK);

    // Abort after three bits, then restart the same word
    load(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_xfer();
    expect_bits(8'hA5, 1'b0, 1'b0, 1'b0, 0, 3);
    stop_en(1'b0);
    @(negedge CLK);
    #1;
    chk("abort_fv", o_fv, 1'b1);
    chk("abort_sd", o_sd, 1'b0);
    expect_bits(8'hA5, 1'b0, 1'b0, 1'b0, 0, 8);
    stop_en(1'b1);
    @(negedge CLK);

    // Narrow instance
    sel = 1'b1;
    full_frame(8'b0001_0011, 1'b0, 1'b1, 1'b0);
    sel = 1'b0;

    // Randomized frames on both widths
    for (int i = 0; i < 24; i++) begin
      logic [7:0] w;
      sel = 1'($urandom_range(0, 1));
      w = 8'($urandom());
      if (sel) w = w & 8'h1F;
      full_frame(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    sel = 1'b0;

    // Asynchronous reset in the middle of a frame with another word buffered
    load(8'h96, 1'b1, 1'b1, 1'b0);
    wait_xfer();
    expect_bits(8'h96, 1'b1, 1'b1, 1'b0, 0, 3);
    pdata = 8'h11; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("midrst_ready", o_ready, 1'b1);
    chk("midrst_fv", o_fv, 1'b0);
    chk("midrst_sd", o_sd, 1'b0);
    chk("midrst_done", o_done, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_rst_fv", o_fv, 1'b0);
    chk("post_rst_ready", o_ready, 1'b1);
    en = 1'b0;
    @(negedge CLK);
    #1 chk("post_rst_no_xfer", o_fv, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
